// File: rtl/gpio_ctrl.sv
// Two-bank GPIO controller: output/enable registers with set/clear/toggle aliases,
// synchronized pad inputs with rising-edge interrupt capture, one-cycle register reads.
module gpio_ctrl #(
    parameter int NUM_PINS = 48
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [7:0]          addr,
    input  logic                wr_en,
    input  logic [3:0]          wr_strb,
    input  logic [31:0]         wr_data,
    input  logic                rd_en,
    output logic [31:0]         rd_data,
    output logic                rd_valid,
    input  logic [NUM_PINS-1:0] gpio_i,
    output logic [NUM_PINS-1:0] gpio_o,
    output logic [NUM_PINS-1:0] gpio_oe,
    output logic                irq
);

    localparam logic [63:0] PIN_MASK = (NUM_PINS >= 64) ? {64{1'b1}}
                                                        : ((64'd1 << NUM_PINS) - 64'd1);

    localparam logic [2:0] REG_IN      = 3'd0;
    localparam logic [2:0] REG_OUT     = 3'd1;
    localparam logic [2:0] REG_OE      = 3'd2;
    localparam logic [2:0] REG_IRQ_EN  = 3'd3;
    localparam logic [2:0] REG_PEND    = 3'd4;
    localparam logic [2:0] REG_OUT_SET = 3'd5;
    localparam logic [2:0] REG_OUT_CLR = 3'd6;
    localparam logic [2:0] REG_OUT_TOG = 3'd7;

    logic [63:0] out_q, out_d;
    logic [63:0] oe_q, oe_d;
    logic [63:0] irq_en_q, irq_en_d;
    logic [63:0] irq_pend_q, irq_pend_d;
    logic [63:0] sync1_q, sync1_d;
    logic [63:0] sync2_q, sync2_d;
    logic [63:0] prev_q, prev_d;
    logic [31:0] rd_data_q, rd_data_d;
    logic        rd_valid_q, rd_valid_d;

    logic [2:0]  reg_idx;
    logic [31:0] byte_mask32;
    logic [63:0] wr_mask;
    logic [63:0] wr_bits;
    logic [63:0] pad_ext;
    logic [63:0] edge_set;
    logic [63:0] w1c_bits;
    logic [63:0] rd_sel;
    logic [31:0] rd_word;
    logic        unused_addr;

    assign reg_idx     = addr[4:2];
    assign unused_addr = ^{addr[7:6], addr[1:0]};

    // Widen the pad bus to the full 64-bit register space.
    always_comb begin
        pad_ext                 = 64'd0;
        pad_ext[NUM_PINS-1:0]   = gpio_i;
    end

    // Position byte-masked write data in the addressed bank, dropping unimplemented pins.
    always_comb begin
        byte_mask32 = {{8{wr_strb[3]}}, {8{wr_strb[2]}}, {8{wr_strb[1]}}, {8{wr_strb[0]}}};
        if (addr[5]) begin
            wr_mask = {byte_mask32, 32'd0} & PIN_MASK;
            wr_bits = {wr_data, 32'd0} & wr_mask;
        end else begin
            wr_mask = {32'd0, byte_mask32} & PIN_MASK;
            wr_bits = {32'd0, wr_data} & wr_mask;
        end
    end

    // Register next-state: host writes, edge capture and the input synchronizer.
    always_comb begin
        out_d    = out_q;
        oe_d     = oe_q;
        irq_en_d = irq_en_q;
        w1c_bits = 64'd0;
        if (wr_en) begin
            case (reg_idx)
                REG_OUT:     out_d    = (out_q & ~wr_mask) | wr_bits;
                REG_OE:      oe_d     = (oe_q & ~wr_mask) | wr_bits;
                REG_IRQ_EN:  irq_en_d = (irq_en_q & ~wr_mask) | wr_bits;
                REG_PEND:    w1c_bits = wr_bits;
                REG_OUT_SET: out_d    = out_q | wr_bits;
                REG_OUT_CLR: out_d    = out_q & ~wr_bits;
                REG_OUT_TOG: out_d    = out_q ^ wr_bits;
                default:     out_d    = out_q;
            endcase
        end else begin
            w1c_bits = 64'd0;
        end
        // A new edge is OR-ed in after the clear so it survives a same-cycle W1C.
        edge_set   = sync2_q & ~prev_q & irq_en_q;
        irq_pend_d = (irq_pend_q & ~w1c_bits) | edge_set;
        sync1_d    = pad_ext & PIN_MASK;
        sync2_d    = sync1_q;
        prev_d     = sync2_q;
    end

    // Read mux samples the registers as they are before this cycle's write.
    always_comb begin
        case (reg_idx)
            REG_IN:     rd_sel = sync2_q;
            REG_OUT:    rd_sel = out_q;
            REG_OE:     rd_sel = oe_q;
            REG_IRQ_EN: rd_sel = irq_en_q;
            REG_PEND:   rd_sel = irq_pend_q;
            default:    rd_sel = 64'd0;
        endcase
        rd_word = addr[5] ? rd_sel[63:32] : rd_sel[31:0];
        if (rd_en) begin
            rd_data_d = rd_word;
        end else begin
            rd_data_d = rd_data_q;
        end
        rd_valid_d = rd_en;
    end

    // All state, cleared synchronously by rst.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_q      <= 64'd0;
            oe_q       <= 64'd0;
            irq_en_q   <= 64'd0;
            irq_pend_q <= 64'd0;
            sync1_q    <= 64'd0;
            sync2_q    <= 64'd0;
            prev_q     <= 64'd0;
            rd_data_q  <= 32'd0;
            rd_valid_q <= 1'b0;
        end else begin
            out_q      <= out_d;
            oe_q       <= oe_d;
            irq_en_q   <= irq_en_d;
            irq_pend_q <= irq_pend_d;
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            prev_q     <= prev_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign gpio_o   = out_q[NUM_PINS-1:0];
    assign gpio_oe  = oe_q[NUM_PINS-1:0];
    assign irq      = |(irq_pend_q & irq_en_q);

endmodule

// File: tb/tb_gpio_ctrl.sv
// Randomized and directed bench for gpio_ctrl against a per-pin behavioural model.
module tb_gpio_ctrl;

    localparam int NP = 48;

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    addr;
    logic          wr_en;
    logic [3:0]    wr_strb;
    logic [31:0]   wr_data;
    logic          rd_en;
    logic [31:0]   rd_data;
    logic          rd_valid;
    logic [NP-1:0] gpio_i;
    logic [NP-1:0] gpio_o;
    logic [NP-1:0] gpio_oe;
    logic          irq;

    always #5 clk = ~clk;

    gpio_ctrl #(.NUM_PINS(NP)) dut (
        .clk      (clk),
        .rst      (rst),
        .addr     (addr),
        .wr_en    (wr_en),
        .wr_strb  (wr_strb),
        .wr_data  (wr_data),
        .rd_en    (rd_en),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .gpio_i   (gpio_i),
        .gpio_o   (gpio_o),
        .gpio_oe  (gpio_oe),
        .irq      (irq)
    );

    // Behavioural model: one entry per pin.
    bit          m_out [64];
    bit          m_oe  [64];
    bit          m_en  [64];
    bit          m_pend[64];
    bit          m_s1  [64];
    bit          m_s2  [64];
    bit          m_prev[64];
    logic [31:0] m_rd;
    bit          m_rv;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    function automatic logic [31:0] model_read(input logic [7:0] a);
        logic [31:0] r;
        int bank;
        int idx;
        r    = 32'd0;
        bank = int'(a[5]);
        idx  = int'(a[4:2]);
        for (int b = 0; b < 32; b++) begin
            int p;
            p = bank * 32 + b;
            if (p < NP) begin
                case (idx)
                    0: r[b] = m_s2[p];
                    1: r[b] = m_out[p];
                    2: r[b] = m_oe[p];
                    3: r[b] = m_en[p];
                    4: r[b] = m_pend[p];
                    default: r[b] = 1'b0;
                endcase
            end
        end
        return r;
    endfunction

    // Advance the model by one clock edge using the currently driven inputs.
    task automatic model_edge();
        if (rst) begin
            for (int p = 0; p < 64; p++) begin
                m_out[p] = 0; m_oe[p] = 0; m_en[p] = 0; m_pend[p] = 0;
                m_s1[p] = 0; m_s2[p] = 0; m_prev[p] = 0;
            end
            m_rd = 32'd0;
            m_rv = 0;
        end else begin
            if (rd_en) m_rd = model_read(addr);
            m_rv = rd_en;
            for (int p = 0; p < NP; p++) begin
                bit set_p, hit, d, clr;
                int idx;
                set_p = m_s2[p] && !m_prev[p] && m_en[p];
                idx   = int'(addr[4:2]);
                hit   = wr_en && (int'(addr[5]) == p / 32) && wr_strb[(p % 32) / 8];
                d     = wr_data[p % 32];
                clr   = 0;
                if (hit) begin
                    case (idx)
                        1: m_out[p] = d;
                        2: m_oe[p]  = d;
                        3: m_en[p]  = d;
                        4: clr      = d;
                        5: if (d) m_out[p] = 1;
                        6: if (d) m_out[p] = 0;
                        7: if (d) m_out[p] = !m_out[p];
                        default: ;
                    endcase
                end
                m_pend[p] = (m_pend[p] && !clr) || set_p;
                m_prev[p] = m_s2[p];
                m_s2[p]   = m_s1[p];
                m_s1[p]   = gpio_i[p];
            end
        end
    endtask

    task automatic compare_outputs();
        logic [63:0] eo, eoe;
        bit ei;
        eo = 64'd0; eoe = 64'd0; ei = 0;
        for (int p = 0; p < NP; p++) begin
            eo[p]  = m_out[p];
            eoe[p] = m_oe[p];
            ei     = ei || (m_pend[p] && m_en[p]);
        end
        check("gpio_o", 64'(gpio_o), eo);
        check("gpio_oe", 64'(gpio_oe), eoe);
        check("irq", 64'(irq), 64'(ei));
        check("rd_valid", 64'(rd_valid), 64'(m_rv));
        check("rd_data", 64'(rd_data), 64'(m_rd));
    endtask

    task automatic cyc(input bit r, input bit w, input bit rd, input logic [7:0] a,
                       input logic [3:0] s, input logic [31:0] d);
        rst = r; wr_en = w; rd_en = rd; addr = a; wr_strb = s; wr_data = d;
        model_edge();
        @(posedge clk);
        #1;
        compare_outputs();
        rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        cyc(1'b0, 1'b1, 1'b0, a, 4'hF, d);
    endtask

    task automatic rd(input logic [7:0] a);
        cyc(1'b0, 1'b0, 1'b1, a, 4'h0, 32'd0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 8'd0, 4'h0, 32'd0);
    endtask

    localparam logic [7:0] A_IN   = 8'h00;
    localparam logic [7:0] A_OUT  = 8'h04;
    localparam logic [7:0] A_OE   = 8'h08;
    localparam logic [7:0] A_EN   = 8'h0C;
    localparam logic [7:0] A_PEND = 8'h10;
    localparam logic [7:0] A_SET  = 8'h14;
    localparam logic [7:0] A_CLR  = 8'h18;
    localparam logic [7:0] A_TOG  = 8'h1C;
    localparam logic [7:0] BANK1  = 8'h20;

    initial begin
        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; addr = 8'd0; wr_strb = 4'h0;
        wr_data = 32'd0; gpio_i = '0;
        for (int p = 0; p < 64; p++) begin
            m_out[p] = 0; m_oe[p] = 0; m_en[p] = 0; m_pend[p] = 0;
            m_s1[p] = 0; m_s2[p] = 0; m_prev[p] = 0;
        end
        m_rd = 32'd0; m_rv = 0;
        cyc(1'b1, 1'b0, 1'b0, 8'd0, 4'h0, 32'd0);
        cyc(1'b1, 1'b0, 1'b0, 8'd0, 4'h0, 32'd0);
        check("reset_gpio_oe", 64'(gpio_oe), 64'd0);
        check("reset_irq", 64'(irq), 64'd0);

        // Basic output path
        wr(A_OE, 32'h0000_00FF);
        check("oe_ff", 64'(gpio_oe[7:0]), 64'hFF);
        wr(A_OUT, 32'h0000_00A5);
        check("out_a5", 64'(gpio_o[7:0]), 64'hA5);
        rd(A_OUT);
        check("rd_out_a5", 64'(rd_data), 64'h0000_00A5);
        check("rd_out_valid", 64'(rd_valid), 64'd1);
        idle(1);
        check("rd_valid_pulse", 64'(rd_valid), 64'd0);

        // Set / clear / toggle aliases
        wr(A_SET, 32'h0F); rd(A_OUT); check("set_af", 64'(rd_data), 64'hAF);
        wr(A_CLR, 32'h01); rd(A_OUT); check("clr_ae", 64'(rd_data), 64'hAE);
        wr(A_TOG, 32'hF0); rd(A_OUT); check("tog_5e", 64'(rd_data), 64'h5E);
        rd(A_SET); check("set_reads_0", 64'(rd_data), 64'd0);

        // Byte strobes
        cyc(1'b0, 1'b1, 1'b0, A_OUT, 4'b0010, 32'h1234_5678);
        rd(A_OUT); check("strobe_byte1", 64'(rd_data), 64'h0000_565E);

        // Bank 1 partial implementation
        wr(BANK1 | A_OUT, 32'hFFFF_FFFF);
        check("b1_gpio_o", 64'(gpio_o[47:32]), 64'hFFFF);
        rd(BANK1 | A_OUT); check("b1_out_rd", 64'(rd_data), 64'h0000_FFFF);

        // Edge interrupt on pin 3
        wr(A_EN, 32'h8);
        gpio_i[3] = 1'b1;
        idle(2);
        check("irq_not_yet", 64'(irq), 64'd0);
        rd(A_IN);
        check("in_bit3", 64'(rd_data[3]), 64'd1);
        check("irq_set", 64'(irq), 64'd1);
        cyc(1'b0, 1'b1, 1'b0, A_PEND, 4'hF, 32'h8);
        check("irq_w1c", 64'(irq), 64'd0);
        gpio_i[4] = 1'b1;
        idle(4);
        rd(A_PEND); check("pin4_no_pend", 64'(rd_data), 64'd0);

        // W1C colliding with a new edge on pin 3
        gpio_i[3] = 1'b0; idle(3);
        gpio_i[3] = 1'b1; idle(3);
        gpio_i[3] = 1'b0; idle(3);
        gpio_i[3] = 1'b1; idle(2);
        cyc(1'b0, 1'b1, 1'b0, A_PEND, 4'hF, 32'h8);
        check("collide_irq", 64'(irq), 64'd1);
        rd(A_PEND); check("collide_pend", 64'(rd_data), 64'h8);

        // Reset mid-operation with a read in flight
        cyc(1'b1, 1'b1, 1'b1, A_OUT, 4'hF, 32'hFFFF_FFFF);
        check("rst_oe", 64'(gpio_oe), 64'd0);
        check("rst_o", 64'(gpio_o), 64'd0);
        check("rst_irq", 64'(irq), 64'd0);
        check("rst_rv", 64'(rd_valid), 64'd0);
        gpio_i = '0;
        for (int i = 0; i < 16; i++) begin
            rd(8'((i / 8) * 32 + (i % 8) * 4));
            check("post_rst_rd", 64'(rd_data), 64'd0);
        end

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            bit r, w, rr;
            if ($urandom_range(0, 3) == 0) gpio_i = gpio_i ^ NP'({$urandom, $urandom} & {$urandom, $urandom});
            r  = ($urandom_range(0, 199) == 0);
            w  = ($urandom_range(0, 1) == 1);
            rr = ($urandom_range(0, 1) == 1);
            cyc(r, w, rr, {2'b00, 6'($urandom)}, 4'($urandom), $urandom);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/gpio_ctrl.md
GPIO_CTRL -- requirements
Module: gpio_ctrl

Interface
REQ-001 Parameter NUM_PINS, default 48, number of GPIO pins (1..64); pins 0-31 are bank 0, pins 32-63 are bank 1.
REQ-002 clk  input  1  system clock; all state changes on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 addr  input  8  byte address; addr[5] = bank, addr[4:2] = register index, addr[1:0] ignored.
REQ-005 wr_en  input  1  write strobe, one cycle per access.
REQ-006 wr_strb  input  4  byte enables for wr_data.
REQ-007 wr_data  input  32  write data.
REQ-008 rd_en  input  1  read strobe, one cycle per access.
REQ-009 rd_data  output  32  read data.
REQ-010 rd_valid  output  1  read data valid pulse.
REQ-011 gpio_i  input  NUM_PINS  pad input values, asynchronous to clk.
REQ-012 gpio_o  output  NUM_PINS  pad output values.
REQ-013 gpio_oe  output  NUM_PINS  pad output enables; 1 = drive. The SoC top builds io_pins tristates from gpio_o and gpio_oe.
REQ-014 irq  output  1  level interrupt request.

Function
REQ-015 Register map per bank, by index: 0 IN (RO), 1 OUT (RW), 2 OE (RW), 3 IRQ_EN (RW), 4 IRQ_PEND (R/W1C), 5 OUT_SET (WO), 6 OUT_CLR (WO), 7 OUT_TOG (WO).
REQ-016 Bits at or above NUM_PINS shall not be implemented: they read 0 and ignore writes, including all of bank 1 when NUM_PINS <= 32.
REQ-017 Writes take effect on the clk edge that samples wr_en, and only on bytes whose wr_strb bit is 1.
REQ-018 OUT_SET, OUT_CLR and OUT_TOG writes shall set, clear or invert the OUT bits where the written data bit is 1 (byte-masked); these registers read 0.
REQ-019 Writing 1 to an IRQ_PEND bit shall clear it; writing 0 has no effect; writes to IN are ignored.
REQ-020 gpio_o = OUT and gpio_oe = OE, driven directly from registers with no added latency.
REQ-021 gpio_i shall pass through a 2-flop synchronizer; IN returns the second-stage value, so a pad change is visible 2 cycles later.
REQ-022 A third flop holds the previous synchronized value; a rising edge is sync2 = 1 and prev = 0.
REQ-023 A rising edge on a pin whose IRQ_EN bit is 1 shall set its IRQ_PEND bit on the next edge; pins with IRQ_EN = 0 never set pending.
REQ-024 If an edge-set and a W1C of the same IRQ_PEND bit occur in the same cycle, the set wins.
REQ-025 Clearing an IRQ_EN bit shall not clear the matching IRQ_PEND bit.
REQ-026 irq = OR over all pins of (IRQ_PEND & IRQ_EN), decoded combinationally from registers.
REQ-027 Read latency is 1 cycle: rd_valid pulses high for one cycle after rd_en, and rd_data holds the addressed register as it was in the rd_en cycle.
REQ-028 When rd_valid is 0, rd_data shall hold its previous value.
REQ-029 Simultaneous rd_en and wr_en to the same register: the read returns the pre-write value and the write is performed.
REQ-030 Reads of write-only or unimplemented locations return 0; writes to them are ignored; no error response is generated.

Reset
REQ-031 While rst = 1 on a clk edge, the following shall clear to 0: OUT, OE, IRQ_EN, IRQ_PEND, synchronizer flops, previous-value flops, rd_data and rd_valid.
REQ-032 Consequences of reset: gpio_o = 0, gpio_oe = 0 (all pins inputs) and irq = 0 from the first cycle after the reset edge.
REQ-033 Reset shall override any concurrent wr_en or rd_en; a read in flight when reset asserts produces no rd_valid.
REQ-034 A pin already high at reset release may produce one rising edge; it sets no pending bit because IRQ_EN = 0.

Verification
REQ-035 Write OE bank0 = 0x0000_00FF, then OUT = 0x0000_00A5 -> gpio_oe[7:0] = 0xFF and gpio_o[7:0] = 0xA5 one cycle after each write; a read of OUT returns 0x0000_00A5 with rd_valid one cycle later.
REQ-036 With OUT = 0xA5: OUT_SET 0x0F, then OUT_CLR 0x01, then OUT_TOG 0xF0 -> OUT reads 0xAF, then 0xAE, then 0x5E; OUT_SET itself reads 0.
REQ-037 Write bank1 OUT = 0xFFFF_FFFF with NUM_PINS = 48 -> gpio_o[47:32] = 0xFFFF and the bank1 OUT read returns 0x0000_FFFF.
REQ-038 IRQ_EN bit 3 = 1, raise gpio_i[3] -> IN bit 3 reads 1 after 2 cycles, IRQ_PEND bit 3 = 1 and irq = 1 by cycle 3; W1C 0x8 -> irq = 0; raise gpio_i[4] with IRQ_EN[4] = 0 -> no pending.
REQ-039 Time a W1C of IRQ_PEND bit 3 to land in the same cycle as a new edge on pin 3 -> bit 3 stays 1 and irq stays 1.
REQ-040 Assert rst mid-operation with OE = 0xFF and pending set, and a read in flight -> next cycle all outputs are 0, no rd_valid, and all registers read 0 after release.
